cn_min2_stream: RTL and testbench

Streaming min-sum check-node magnitude engine for the QC-LDPC decoder. Accepts a check node's variable-to-check messages as LANES signed values per beat over one or more beats. Tracks the smallest magnitude (min1), its global position (idx), the second-smallest magnitude (min2) and the XOR of all signs. It is the sequential, multi-beat, masked, back-pressured successor of the single-shot find-min-index tree.

---
 rtl/cn_pkg.sv | 59 +++++
 rtl/cn_min2_tree.sv | 31 +++
 rtl/cn_min2_stream.sv | 108 ++++++++++
 tb/tb_cn_min2_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cn_pkg.sv
// Shared widths, result struct and arithmetic helpers for the min-sum check-node engine.
// The package widths set the datapath; the top-level BITS/DEG_MAX defaults track them.
package cn_pkg;

  localparam int CN_BITS    = 8;
  localparam int CN_DEG_MAX = 64;

  function automatic int mag_width(input int bits);
    return bits - 1;
  endfunction

  function automatic int idx_width(input int deg_max);
    return (deg_max > 1) ? $clog2(deg_max) : 1;
  endfunction

  localparam int MAG_W = mag_width(CN_BITS);
  localparam int IDX_W = idx_width(CN_DEG_MAX);

  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

  typedef struct packed {
    logic [MAG_W-1:0] min1;
    logic [MAG_W-1:0] min2;
    logic [IDX_W-1:0] idx;
    logic             sign;
  } cn_res_t;

  localparam cn_res_t RES_INIT = '{min1: MAG_MAX, min2: MAG_MAX, idx: '0, sign: 1'b0};

  // The most negative code has no positive twin, so it clamps to MAG_MAX.
  function automatic logic [MAG_W-1:0] sat_abs(input logic [CN_BITS-1:0] x);
    logic [CN_BITS-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[CN_BITS-1]) begin
      return x[MAG_W-1:0];
    end else if (neg[CN_BITS-1]) begin
      return MAG_MAX;
    end else begin
      return neg[MAG_W-1:0];
    end
  endfunction

  // lo must hold the lower global indices so that ties keep lo's min1 and idx.
  function automatic cn_res_t cn_merge(input cn_res_t lo, input cn_res_t hi);
    cn_res_t r;
    r.sign = lo.sign ^ hi.sign;
    if (hi.min1 < lo.min1) begin
      r.min1 = hi.min1;
      r.idx  = hi.idx;
      r.min2 = (lo.min1 < hi.min2) ? lo.min1 : hi.min2;
    end else begin
      r.min1 = lo.min1;
      r.idx  = lo.idx;
      r.min2 = (hi.min1 < lo.min2) ? hi.min1 : lo.min2;
    end
    return r;
  endfunction

endpackage

// File: rtl/cn_min2_tree.sv
// Combinational LANES-input min1/min2/idx/sign reducer, log2(LANES) levels of pairwise merges.
// Masked lanes enter as MAG_MAX with no sign; idx is the local lane number.
module cn_min2_tree
  import cn_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0][CN_BITS-1:0] data,
  input  logic [LANES-1:0]              mask,
  output cn_res_t                       res
);

  cn_res_t stage [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      stage[l].min1 = mask[l] ? sat_abs(data[l]) : MAG_MAX;
      stage[l].min2 = MAG_MAX;
      stage[l].idx  = IDX_W'(l);
      stage[l].sign = mask[l] & data[l][CN_BITS-1];
    end
    // In-place halving: slot j at each level only reads slots 2j and 2j+1, which are not yet overwritten.
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        stage[j] = cn_merge(stage[2*j], stage[2*j+1]);
      end
    end
    res = stage[0];
  end

endmodule

// File: rtl/cn_min2_stream.sv
// Streaming min-sum check-node engine: result one cycle after the last beat; input stalls while a result is held.
// Define CN_OFFSET_EN to subtract OFFSET (floored at 0) from the output magnitudes.
module cn_min2_stream
  import cn_pkg::*;
#(
  parameter int BITS    = CN_BITS,
  parameter int LANES   = 4,
  parameter int DEG_MAX = CN_DEG_MAX,
  parameter int OFFSET  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][BITS-1:0]   in_data,
  input  logic [LANES-1:0]             in_mask,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITS-2:0]              out_min1,
  output logic [BITS-2:0]              out_min2,
  output logic [$clog2(DEG_MAX)-1:0]   out_idx,
  output logic                         out_sign,
  output logic                         out_err
);

  localparam int NBEATS = DEG_MAX / LANES;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int LANE_W = $clog2(LANES);

`ifdef CN_OFFSET_EN
  localparam int OFF_EFF = OFFSET;
`else
  localparam int OFF_EFF = 0 * OFFSET;
`endif

  function automatic logic [MAG_W-1:0] apply_off(input logic [MAG_W-1:0] m);
    return (int'(m) > OFF_EFF) ? MAG_W'(int'(m) - OFF_EFF) : '0;
  endfunction

  cn_res_t             acc;
  cn_res_t             tree_res;
  cn_res_t             beat_res;
  cn_res_t             merged;
  logic [BEAT_W-1:0]   beat;
  logic                beat_full;
  logic                accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  cn_min2_tree #(
    .LANES (LANES)
  ) u_tree (
    .data (in_data),
    .mask (in_mask),
    .res  (tree_res)
  );

  // Lane index occupies the low LANE_W bits, the beat number the rest.
  always_comb begin
    beat_res     = tree_res;
    beat_res.idx = tree_res.idx | (IDX_W'(beat) << LANE_W);
    merged       = cn_merge(acc, beat_res);
  end

  // beat_full marks that every index slot of the frame is used; any further beat overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= RES_INIT;
      beat      <= '0;
      beat_full <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc       <= RES_INIT;
        beat      <= '0;
        beat_full <= 1'b0;
      end else begin
        acc  <= merged;
        beat <= beat + 1'b1;
        if (beat == BEAT_W'(NBEATS - 1)) begin
          beat_full <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_min1  <= MAG_MAX;
      out_min2  <= MAG_MAX;
      out_idx   <= '0;
      out_sign  <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept && in_last) begin
      out_valid <= 1'b1;
      out_min1  <= apply_off(merged.min1);
      out_min2  <= apply_off(merged.min2);
      out_idx   <= merged.idx;
      out_sign  <= merged.sign;
      out_err   <= beat_full;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cn_min2_stream.sv
// Directed-vector bench for cn_min2_stream (BITS=8, LANES=4, DEG_MAX=64, OFFSET=2).
module tb_cn_min2_stream;

  localparam int OFF = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_mask;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_min1;
  logic [6:0]      out_min2;
  logic [5:0]      out_idx;
  logic            out_sign;
  logic            out_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cn_min2_stream #(
    .BITS    (8),
    .LANES   (4),
    .DEG_MAX (64),
    .OFFSET  (OFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min1  (out_min1),
    .out_min2  (out_min2),
    .out_idx   (out_idx),
    .out_sign  (out_sign),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected output magnitude after the optional offset stage.
  function automatic int om(input int m);
`ifdef CN_OFFSET_EN
    return (m > OFF) ? m - OFF : 0;
`else
    return m;
`endif
  endfunction

  task automatic set_beat(input int d0, input int d1, input int d2, input int d3,
                          input logic [3:0] m, input logic l);
    in_data[0] = 8'(d0);
    in_data[1] = 8'(d1);
    in_data[2] = 8'(d2);
    in_data[3] = 8'(d3);
    in_mask    = m;
    in_last    = l;
    in_valid   = 1'b1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic beat(input int d0, input int d1, input int d2, input int d3,
                      input logic [3:0] m, input logic l);
    int n;
    set_beat(d0, d1, d2, d3, m, l);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) chk("beat.ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic exp_res(input string tag, input int m1, input int m2, input int idx,
                         input int sign, input int err);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".min1"}, out_min1, om(m1));
    chk({tag, ".min2"}, out_min2, om(m2));
    chk({tag, ".idx"}, out_idx, idx);
    chk({tag, ".sign"}, out_sign, sign);
    chk({tag, ".err"}, out_err, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd [3][4];
    int bm [3];
    int be [3][4];

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mask = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.valid", out_valid, 0);
    chk("rst.min1", out_min1, 127);
    chk("rst.min2", out_min2, 127);
    chk("rst.idx", out_idx, 0);
    chk("rst.sign", out_sign, 0);
    chk("rst.err", out_err, 0);

    beat(-3, 5, 2, 7, 4'b1111, 1'b1);
    exp_res("c1", 2, 3, 2, 1, 0);

    beat(9, -4, 6, 8, 4'b1111, 1'b0);
    chk("c2.mid_valid", out_valid, 0);
    beat(1, 10, -1, 12, 4'b1111, 1'b1);
    exp_res("c2", 1, 1, 4, 0, 0);

    beat(-128, 3, 4, 5, 4'b1110, 1'b1);
    exp_res("c3a", 3, 4, 1, 0, 0);
    beat(-128, 3, 4, 5, 4'b1111, 1'b1);
    exp_res("c3b", 3, 4, 1, 1, 0);

    // Stall the held result with a last beat pending.
    out_ready = 1'b0;
    set_beat(-5, 8, 6, -7, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", in_ready, 0);
      exp_res("bp.hold", 3, 4, 1, 1, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_res("bp.new", 5, 6, 0, 0, 0);

    // Back-to-back single-beat frames.
    bd = '{'{0, 1, 2, 3}, '{-1, -1, 5, 5}, '{7, 6, -2, 100}};
    bm = '{4'b1111, 4'b1111, 4'b0111};
    be = '{'{0, 1, 0, 0}, '{1, 1, 0, 0}, '{2, 6, 2, 1}};
    for (int f = 0; f < 3; f++) begin
      set_beat(bd[f][0], bd[f][1], bd[f][2], bd[f][3], bm[f], 1'b1);
      #1;
      chk("b2b.in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      exp_res("b2b", be[f][0], be[f][1], be[f][2], be[f][3], 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Reset mid-frame and with a result held.
    out_ready = 1'b0;
    beat(1, 1, 1, 1, 4'b1111, 1'b0);
    out_ready = 1'b1;
    beat(2, 2, 2, 2, 4'b1111, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mrst.valid", out_valid, 0);
    beat(6, 4, 4, 9, 4'b1111, 1'b1);
    exp_res("mrst", 4, 4, 1, 0, 0);

    beat(50, -20, 9, 9, 4'b0010, 1'b1);
    exp_res("single", 20, 127, 1, 1, 0);

    beat(-1, -2, -3, -4, 4'b0000, 1'b1);
    exp_res("empty", 127, 127, 0, 0, 0);

    // Exactly DEG_MAX entries: no error, min at the highest index.
    for (int b = 0; b < 15; b++) beat(10, 20, 30, 40, 4'b1111, 1'b0);
    beat(10, 20, 30, 3, 4'b1111, 1'b1);
    exp_res("deg64", 3, 10, 63, 0, 0);

    // 17 beats: counter wraps so the 17th beat's lane 1 lands on index 1.
    for (int b = 0; b < 16; b++) beat(10, 20, 30, 40, 4'b1111, 1'b0);
    beat(10, -2, 30, 40, 4'b1111, 1'b1);
    exp_res("ovf", 2, 10, 1, 1, 1);

    beat(5, 5, 5, 5, 4'b1111, 1'b1);
    exp_res("post_ovf", 5, 5, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
